sync_gearbox_fifo: RTL and testbench

SYNC_GEARBOX_FIFO -- requirements
Module: sync_gearbox_fifo

---
 rtl/sync_gearbox_fifo.sv | 151 +++++++++++++++
 tb/tb_sync_gearbox_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_gearbox_fifo.sv
// sync_gearbox_fifo
// Single-clock FIFO whose write and read words are different multiples of a
// DATA_WIDTH storage unit. Occupancy is tracked in units, so a wide write and
// a narrow read (or the reverse) share one circular unit memory.
//
// Ports:
//   clk         single clock
//   rstN        asynchronous active-low reset
//   wrEn/din    write request and write word (lane i = unit wrPtr+i)
//   fifoFull    fewer than WR_DATA_WIDTH_MUL free units
//   almostFull  count >= AF_THRESH
//   rdEn        read request / pop
//   dout        read word (lane i = unit rdPtr+i)
//   dataValid   dout holds freshly popped data (FWFT=0) or head data (FWFT=1)
//   fifoEmpty   fewer than RD_DATA_WIDTH_MUL units stored
//   almostEmpty count <= AE_THRESH
//   count       occupancy in units
//   overflow    sticky write-while-full flag
//   underflow   sticky read-while-empty flag
//   clrErr      clears overflow/underflow (a new error in the same cycle wins)
module sync_gearbox_fifo #(
    parameter int DATA_WIDTH        = 8,
    parameter int WR_DATA_WIDTH_MUL = 1,
    parameter int RD_DATA_WIDTH_MUL = 1,
    parameter int ADDRESS_WIDTH     = 4,
    parameter int FWFT              = 0,
    parameter int AF_THRESH         = (2**ADDRESS_WIDTH) - WR_DATA_WIDTH_MUL,
    parameter int AE_THRESH         = RD_DATA_WIDTH_MUL
) (
    input  logic                                      clk,
    input  logic                                      rstN,
    input  logic                                      wrEn,
    input  logic [WR_DATA_WIDTH_MUL*DATA_WIDTH-1:0]   din,
    output logic                                      fifoFull,
    output logic                                      almostFull,
    input  logic                                      rdEn,
    output logic [RD_DATA_WIDTH_MUL*DATA_WIDTH-1:0]   dout,
    output logic                                      dataValid,
    output logic                                      fifoEmpty,
    output logic                                      almostEmpty,
    output logic [ADDRESS_WIDTH:0]                    count,
    output logic                                      overflow,
    output logic                                      underflow,
    input  logic                                      clrErr
);

    localparam int FIFO_DEPTH = 2**ADDRESS_WIDTH;
    localparam int PW         = ADDRESS_WIDTH + 1;
    localparam int RW         = RD_DATA_WIDTH_MUL * DATA_WIDTH;

    localparam logic [PW-1:0] WR_STEP     = PW'(WR_DATA_WIDTH_MUL);
    localparam logic [PW-1:0] RD_STEP     = PW'(RD_DATA_WIDTH_MUL);
    localparam logic [31:0]   FULL_LIMIT  = 32'(FIFO_DEPTH - WR_DATA_WIDTH_MUL);
    localparam logic [31:0]   EMPTY_LIMIT = 32'(RD_DATA_WIDTH_MUL);
    localparam logic [31:0]   AF_LIMIT    = 32'(AF_THRESH);
    localparam logic [31:0]   AE_LIMIT    = 32'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [31:0]           w_count_ext;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [RW-1:0]         w_rd_word;

    // Flags are derived from the registered count only; thresholds are compared
    // at 32 bits so multipliers larger than the depth still behave sensibly.
    assign w_count_ext = 32'(r_count);
    assign w_full      = (w_count_ext > FULL_LIMIT);
    assign w_empty     = (w_count_ext < EMPTY_LIMIT);
    assign w_wr_acc    = wrEn & ~w_full;
    assign w_rd_acc    = rdEn & ~w_empty;

    assign fifoFull    = w_full;
    assign fifoEmpty   = w_empty;
    assign almostFull  = (w_count_ext >= AF_LIMIT);
    assign almostEmpty = (w_count_ext <= AE_LIMIT);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_count     <= {PW{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + (w_wr_acc ? WR_STEP : {PW{1'b0}});
            r_rd_ptr    <= r_rd_ptr + (w_rd_acc ? RD_STEP : {PW{1'b0}});
            r_count     <= r_count + (w_wr_acc ? WR_STEP : {PW{1'b0}})
                                   - (w_rd_acc ? RD_STEP : {PW{1'b0}});
            r_overflow  <= (wrEn & w_full)  | (r_overflow  & ~clrErr);
            r_underflow <= (rdEn & w_empty) | (r_underflow & ~clrErr);
        end
    end

    // Unit memory write; each write lane lands at consecutive unit addresses.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < WR_DATA_WIDTH_MUL; i++) begin
                r_mem[r_wr_ptr[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(i)] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Assemble the head read word from consecutive units starting at rdPtr.
    always_comb begin
        w_rd_word = {RW{1'b0}};
        for (int i = 0; i < RD_DATA_WIDTH_MUL; i++) begin
            w_rd_word[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(i)];
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible whenever a full read word is stored; it is
            // forced to zero while empty so reset and idle output is defined.
            assign dout      = w_empty ? {RW{1'b0}} : w_rd_word;
            assign dataValid = ~w_empty;
        end else begin : g_registered
            logic [RW-1:0] r_dout;
            logic          r_data_valid;

            // Registered read port: capture on accepted pop, hold otherwise.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    r_dout       <= {RW{1'b0}};
                    r_data_valid <= 1'b0;
                end else begin
                    if (w_rd_acc) begin
                        r_dout <= w_rd_word;
                    end
                    r_data_valid <= w_rd_acc;
                end
            end

            assign dout      = r_dout;
            assign dataValid = r_data_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sync_gearbox_fifo.sv
// Bench for sync_gearbox_fifo: three instances cover a 2:1 write/read gearbox,
// a 1:2 gearbox and first-word-fall-through mode. Expected values come from
// unit-level queue models and constants derived from the FIFO rules.
module tb_sync_gearbox_fifo;

    logic clk;
    logic clk_run;
    logic rstN;
    int   n_pass;
    int   n_total;

    // Instance A: WR_MUL=2, RD_MUL=1, registered read
    logic        a_wrEn, a_rdEn, a_clr;
    logic [15:0] a_din;
    logic [7:0]  a_dout;
    logic        a_full, a_af, a_dv, a_empty, a_ae, a_ovf, a_udf;
    logic [4:0]  a_count;

    // Instance B: WR_MUL=1, RD_MUL=2, registered read
    logic        b_wrEn, b_rdEn, b_clr;
    logic [7:0]  b_din;
    logic [15:0] b_dout;
    logic        b_full, b_af, b_dv, b_empty, b_ae, b_ovf, b_udf;
    logic [4:0]  b_count;

    // Instance C: WR_MUL=1, RD_MUL=1, FWFT
    logic        c_wrEn, c_rdEn, c_clr;
    logic [7:0]  c_din;
    logic [7:0]  c_dout;
    logic        c_full, c_af, c_dv, c_empty, c_ae, c_ovf, c_udf;
    logic [4:0]  c_count;

    logic [7:0] qa[$];

    sync_gearbox_fifo #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(2), .RD_DATA_WIDTH_MUL(1),
                        .ADDRESS_WIDTH(4), .FWFT(0)) u_a (
        .clk(clk), .rstN(rstN), .wrEn(a_wrEn), .din(a_din), .fifoFull(a_full),
        .almostFull(a_af), .rdEn(a_rdEn), .dout(a_dout), .dataValid(a_dv),
        .fifoEmpty(a_empty), .almostEmpty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf), .clrErr(a_clr));

    sync_gearbox_fifo #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(2),
                        .ADDRESS_WIDTH(4), .FWFT(0)) u_b (
        .clk(clk), .rstN(rstN), .wrEn(b_wrEn), .din(b_din), .fifoFull(b_full),
        .almostFull(b_af), .rdEn(b_rdEn), .dout(b_dout), .dataValid(b_dv),
        .fifoEmpty(b_empty), .almostEmpty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf), .clrErr(b_clr));

    sync_gearbox_fifo #(.DATA_WIDTH(8), .WR_DATA_WIDTH_MUL(1), .RD_DATA_WIDTH_MUL(1),
                        .ADDRESS_WIDTH(4), .FWFT(1)) u_c (
        .clk(clk), .rstN(rstN), .wrEn(c_wrEn), .din(c_din), .fifoFull(c_full),
        .almostFull(c_af), .rdEn(c_rdEn), .dout(c_dout), .dataValid(c_dv),
        .fifoEmpty(c_empty), .almostEmpty(c_ae), .count(c_count),
        .overflow(c_ovf), .underflow(c_udf), .clrErr(c_clr));

    // Gateable clock so the reset-with-clock-stopped case can be exercised.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic test_reset();
        rstN = 1'b0; clk_run = 1'b1;
        a_wrEn = 1'b0; a_rdEn = 1'b0; a_clr = 1'b0; a_din = 16'h0000;
        b_wrEn = 1'b0; b_rdEn = 1'b0; b_clr = 1'b0; b_din = 8'h00;
        c_wrEn = 1'b0; c_rdEn = 1'b0; c_clr = 1'b0; c_din = 8'h00;
        #2;
        n_total++; if (a_count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", a_count); else n_pass++;
        n_total++; if ({a_empty, a_full, a_ae, a_af} !== 4'b1010) $display("FAIL reset_flags: got %b expected 1010", {a_empty, a_full, a_ae, a_af}); else n_pass++;
        n_total++; if ({a_dout, a_dv, a_ovf, a_udf} !== 11'd0) $display("FAIL reset_dout_dv_err: got %h expected 0", {a_dout, a_dv, a_ovf, a_udf}); else n_pass++;
        n_total++; if ({c_dout, c_dv} !== 9'd0) $display("FAIL reset_fwft_out: got %h expected 0", {c_dout, c_dv}); else n_pass++;
        @(negedge clk); @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wide_write_narrow_read();
        a_wrEn = 1'b1; a_din = 16'hBBAA;
        @(negedge clk);
        a_wrEn = 1'b0;
        n_total++; if (a_count !== 5'd2) $display("FAIL w2r1_count_after_write: got %0d expected 2", a_count); else n_pass++;
        a_rdEn = 1'b1;
        @(negedge clk);
        n_total++; if ({a_count, a_dout, a_dv} !== {5'd1, 8'hAA, 1'b1}) $display("FAIL w2r1_first_read: got cnt=%0d dout=%h dv=%b expected cnt=1 dout=aa dv=1", a_count, a_dout, a_dv); else n_pass++;
        @(negedge clk);
        a_rdEn = 1'b0;
        n_total++; if ({a_count, a_dout, a_dv} !== {5'd0, 8'hBB, 1'b1}) $display("FAIL w2r1_second_read: got cnt=%0d dout=%h dv=%b expected cnt=0 dout=bb dv=1", a_count, a_dout, a_dv); else n_pass++;
        @(negedge clk);
        n_total++; if ({a_dout, a_dv, a_empty} !== {8'hBB, 1'b0, 1'b1}) $display("FAIL w2r1_hold: got dout=%h dv=%b empty=%b expected bb 0 1", a_dout, a_dv, a_empty); else n_pass++;
    endtask

    task automatic test_full_overflow();
        logic [15:0] w;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            w = 16'($urandom);
            a_wrEn = 1'b1; a_din = w;
            qa.push_back(w[7:0]); qa.push_back(w[15:8]);
        end
        @(negedge clk);
        n_total++; if ({a_count, a_full} !== {5'd14, 1'b0}) $display("FAIL full_after7: got cnt=%0d full=%b expected 14 0", a_count, a_full); else n_pass++;
        w = 16'($urandom);
        a_din = w; qa.push_back(w[7:0]); qa.push_back(w[15:8]);
        @(negedge clk);
        n_total++; if ({a_count, a_full, a_af, a_ovf} !== {5'd16, 1'b1, 1'b1, 1'b0}) $display("FAIL full_after8: got cnt=%0d full=%b af=%b ovf=%b expected 16 1 1 0", a_count, a_full, a_af, a_ovf); else n_pass++;
        a_din = 16'hDEAD;
        @(negedge clk);
        a_wrEn = 1'b0;
        n_total++; if ({a_count, a_ovf} !== {5'd16, 1'b1}) $display("FAIL overflow_set: got cnt=%0d ovf=%b expected 16 1", a_count, a_ovf); else n_pass++;
        @(negedge clk);
        n_total++; if (a_ovf !== 1'b1) $display("FAIL overflow_sticky: got %b expected 1", a_ovf); else n_pass++;
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        n_total++; if (a_ovf !== 1'b0) $display("FAIL overflow_clear: got %b expected 0", a_ovf); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [15:0] w;
        logic [7:0]  head;
        @(negedge clk);
        a_rdEn = 1'b1;
        @(negedge clk);
        head = qa.pop_front();
        n_total++; if ({a_count, a_dout} !== {5'd15, head}) $display("FAIL sim_read1: got cnt=%0d dout=%h expected 15 %h", a_count, a_dout, head); else n_pass++;
        @(negedge clk);
        head = qa.pop_front();
        n_total++; if ({a_count, a_dout} !== {5'd14, head}) $display("FAIL sim_read2: got cnt=%0d dout=%h expected 14 %h", a_count, a_dout, head); else n_pass++;
        w = 16'($urandom);
        a_wrEn = 1'b1; a_din = w;
        head = qa.pop_front();
        qa.push_back(w[7:0]); qa.push_back(w[15:8]);
        @(negedge clk);
        a_wrEn = 1'b0; a_rdEn = 1'b0;
        n_total++; if ({a_count, a_full, a_dout, a_dv} !== {5'd15, 1'b1, head, 1'b1}) $display("FAIL sim_wr_rd: got cnt=%0d full=%b dout=%h dv=%b expected 15 1 %h 1", a_count, a_full, a_dout, a_dv, head); else n_pass++;
        @(negedge clk);
        a_rdEn = 1'b1;
        while (qa.size() > 0) begin
            @(negedge clk);
            head = qa.pop_front();
            if (qa.size() == 0) a_rdEn = 1'b0;
            n_total++; if (a_dout !== head) $display("FAIL drain_order: got %h expected %h", a_dout, head); else n_pass++;
        end
        n_total++; if ({a_count, a_empty} !== {5'd0, 1'b1}) $display("FAIL drain_empty: got cnt=%0d empty=%b expected 0 1", a_count, a_empty); else n_pass++;
        head = a_dout;
        a_rdEn = 1'b1;
        @(negedge clk);
        a_rdEn = 1'b0;
        n_total++; if ({a_udf, a_dv, a_count} !== {1'b1, 1'b0, 5'd0}) $display("FAIL underflow_set: got udf=%b dv=%b cnt=%0d expected 1 0 0", a_udf, a_dv, a_count); else n_pass++;
        n_total++; if (a_dout !== head) $display("FAIL underflow_dout_hold: got %h expected %h", a_dout, head); else n_pass++;
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        n_total++; if (a_udf !== 1'b0) $display("FAIL underflow_clear: got %b expected 0", a_udf); else n_pass++;
    endtask

    task automatic test_narrow_write_wide_read();
        b_wrEn = 1'b1; b_din = 8'h11;
        @(negedge clk);
        b_wrEn = 1'b0;
        n_total++; if ({b_count, b_empty} !== {5'd1, 1'b1}) $display("FAIL w1r2_one_unit: got cnt=%0d empty=%b expected 1 1", b_count, b_empty); else n_pass++;
        b_rdEn = 1'b1;
        @(negedge clk);
        b_rdEn = 1'b0;
        n_total++; if ({b_udf, b_count, b_dv} !== {1'b1, 5'd1, 1'b0}) $display("FAIL w1r2_underflow: got udf=%b cnt=%0d dv=%b expected 1 1 0", b_udf, b_count, b_dv); else n_pass++;
        b_wrEn = 1'b1; b_din = 8'h22;
        @(negedge clk);
        b_wrEn = 1'b0;
        n_total++; if ({b_count, b_empty} !== {5'd2, 1'b0}) $display("FAIL w1r2_two_units: got cnt=%0d empty=%b expected 2 0", b_count, b_empty); else n_pass++;
        b_rdEn = 1'b1;
        @(negedge clk);
        b_rdEn = 1'b0;
        n_total++; if ({b_dout, b_dv, b_count} !== {16'h2211, 1'b1, 5'd0}) $display("FAIL w1r2_read: got dout=%h dv=%b cnt=%0d expected 2211 1 0", b_dout, b_dv, b_count); else n_pass++;
    endtask

    task automatic test_fwft();
        c_wrEn = 1'b1; c_din = 8'h5A;
        @(negedge clk);
        c_wrEn = 1'b0;
        n_total++; if ({c_dout, c_dv, c_count} !== {8'h5A, 1'b1, 5'd1}) $display("FAIL fwft_fallthrough: got dout=%h dv=%b cnt=%0d expected 5a 1 1", c_dout, c_dv, c_count); else n_pass++;
        c_rdEn = 1'b1;
        @(negedge clk);
        c_rdEn = 1'b0;
        n_total++; if ({c_dv, c_empty} !== {1'b0, 1'b1}) $display("FAIL fwft_pop_empty: got dv=%b empty=%b expected 0 1", c_dv, c_empty); else n_pass++;
        c_wrEn = 1'b1; c_din = 8'h01;
        @(negedge clk);
        c_din = 8'h02;
        @(negedge clk);
        c_wrEn = 1'b0;
        n_total++; if (c_dout !== 8'h01) $display("FAIL fwft_head: got %h expected 01", c_dout); else n_pass++;
        c_rdEn = 1'b1;
        @(negedge clk);
        c_rdEn = 1'b0;
        n_total++; if ({c_dout, c_dv} !== {8'h02, 1'b1}) $display("FAIL fwft_next: got dout=%h dv=%b expected 02 1", c_dout, c_dv); else n_pass++;
    endtask

    task automatic test_stream_and_reset();
        int          written = 0;
        int          nread   = 0;
        int          cycles  = 0;
        int          sz;
        logic        wr, rd, exp_dv;
        logic [7:0]  exp_dout;
        logic [15:0] w;
        exp_dv = 1'b0; exp_dout = a_dout;
        qa.delete();
        while ((nread < 40 || exp_dv) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            n_total++; if (a_count !== 5'(qa.size()) || a_count > 5'd16) $display("FAIL stream_count: got %0d expected %0d", a_count, qa.size()); else n_pass++;
            n_total++; if ({a_dv, a_dout} !== {exp_dv, exp_dout}) $display("FAIL stream_data: got dv=%b dout=%h expected %b %h", a_dv, a_dout, exp_dv, exp_dout); else n_pass++;
            wr = (written < 20) && ($urandom_range(0, 1) == 1);
            rd = (nread < 40) && ($urandom_range(0, 1) == 1);
            w  = 16'($urandom);
            a_wrEn = wr; a_rdEn = rd; a_din = w;
            sz = qa.size();
            exp_dv = rd && (sz >= 1);
            if (exp_dv) begin
                exp_dout = qa.pop_front();
                nread++;
            end
            if (wr && sz <= 14) begin
                qa.push_back(w[7:0]); qa.push_back(w[15:8]);
                written++;
            end
        end
        a_wrEn = 1'b0; a_rdEn = 1'b0;
        n_total++; if (cycles >= 3000) $display("FAIL stream_timeout: got %0d units read expected 40", nread); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_wrEn = 1'b1; a_din = 16'($urandom);
        end
        @(negedge clk);
        a_wrEn = 1'b0; a_rdEn = 1'b1;
        @(negedge clk);
        a_rdEn = 1'b0;
        n_total++; if (a_count !== 5'd9) $display("FAIL pre_reset_count: got %0d expected 9", a_count); else n_pass++;
        clk_run = 1'b0;
        #2 rstN = 1'b0;
        #1;
        n_total++; if ({a_count, a_empty, a_ae, a_dv} !== {5'd0, 1'b1, 1'b1, 1'b0}) $display("FAIL async_reset: got cnt=%0d empty=%b ae=%b dv=%b expected 0 1 1 0", a_count, a_empty, a_ae, a_dv); else n_pass++;
        #2 rstN = 1'b1;
        clk_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++; if ({a_count, a_empty} !== {5'd0, 1'b1}) $display("FAIL post_reset_empty: got cnt=%0d empty=%b expected 0 1", a_count, a_empty); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_wide_write_narrow_read();
        test_full_overflow();
        test_simultaneous();
        test_narrow_write_wide_read();
        test_fwft();
        test_stream_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
